arty_input_debounce: RTL and testbench

//  Conditions raw Arty board buttons/switches before they reach the Btn/Sw CSR read path.
//  Per bit: synchronises the asynchronous pad input, debounces it with a stability counter
//  and emits one-cycle rise/fall pulses.

---
 rtl/arty_input_debounce.sv | 108 ++++++++++
 tb/tb_arty_input_debounce.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/arty_input_debounce.sv
// Per-bit synchroniser, stability-counter debouncer and edge-pulse generator for Arty buttons/switches.
// Optional sticky edge-pending bits and interrupt request are built when INPUT_DEBOUNCE_IRQ_EN is defined.
module arty_input_debounce #(
  parameter int Width          = 4,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 20000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] stable_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  input  logic [Width-1:0] clr_i,
  output logic [Width-1:0] pend_o,
  output logic             irq_o
);

  localparam int              CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntTerm = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0][Width-1:0] sync_d, sync_q;
  logic [Width-1:0][CntW-1:0]       cnt_d, cnt_q;
  logic [Width-1:0]                 stable_d, stable_q;
  logic [Width-1:0]                 rise_d, rise_q;
  logic [Width-1:0]                 fall_d, fall_q;
  logic [Width-1:0]                 sync_s;

  // Plain shift chain: stage 0 captures the pad, the last stage is the synchronised level.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = raw_i;
    for (int k = 1; k < SyncStages; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SyncStages-1];

  // Terminal compare comes before the increment so the counter never wraps.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < Width; i++) begin
      if (sync_s[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntTerm) begin
        cnt_d[i]    = '0;
        stable_d[i] = sync_s[i];
        rise_d[i]   = sync_s[i];
        fall_d[i]   = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  // Synchroniser, counters, debounced level and edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

`ifdef INPUT_DEBOUNCE_IRQ_EN
  logic [Width-1:0] pend_d, pend_q;

  // A new edge outranks a simultaneous clear so no edge is ever lost.
  always_comb begin
    pend_d = (pend_q & ~clr_i) | rise_q | fall_q;
  end

  // Sticky pending bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
  assign irq_o  = |pend_q;
`else
  logic unused_clr_s;

  assign unused_clr_s = ^clr_i;
  assign pend_o       = '0;
  assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_arty_input_debounce.sv
// Directed bench for arty_input_debounce (Width=4, SyncStages=2, DebounceCycles=4).
// Expected pend/irq values follow whether INPUT_DEBOUNCE_IRQ_EN is defined.
module tb_arty_input_debounce;

`ifdef INPUT_DEBOUNCE_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] raw_i;
  logic [3:0] stable_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic [3:0] clr_i;
  logic [3:0] pend_o;
  logic       irq_o;

  int checks;
  int failures;
  int rise_cnt;

  arty_input_debounce #(
    .Width(4),
    .SyncStages(2),
    .DebounceCycles(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_i(raw_i),
    .stable_o(stable_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .clr_i(clr_i),
    .pend_o(pend_o),
    .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stable"}, 32'(stable_o), 32'h0);
    chk({tag, "_rise"}, 32'(rise_o), 32'h0);
    chk({tag, "_fall"}, 32'(fall_o), 32'h0);
    chk({tag, "_pend"}, 32'(pend_o), 32'h0);
    chk({tag, "_irq"}, 32'(irq_o), 32'h0);
  endtask

  initial begin
    logic [11:0] bounce;
    checks   = 0;
    failures = 0;
    bounce   = 12'b000111000111;

    // 1. reset held with pads high
    reset_n = 1'b0;
    raw_i   = 4'hF;
    clr_i   = 4'h0;
    #1;
    chk_quiet("rst0");
    step(3);
    chk_quiet("rst3");
    raw_i = 4'h0;
    step(1);
    reset_n = 1'b1;
    step(4);
    chk("idle_stable", 32'(stable_o), 32'h0);

    // 2. clean press on bit 0
    raw_i = 4'h1;
    step(5);
    chk("press_before", 32'(stable_o), 32'h0);
    chk("press_before_rise", 32'(rise_o), 32'h0);
    step(1);
    chk("press_stable", 32'(stable_o), 32'h1);
    chk("press_rise", 32'(rise_o), 32'h1);
    step(1);
    chk("press_rise_end", 32'(rise_o), 32'h0);
    chk("press_hold", 32'(stable_o), 32'h1);

    // 3. bounce on bit 1: 3-cycle highs never qualify
    rise_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      raw_i[1] = bounce[j];
      step(1);
      if (rise_o[1]) rise_cnt++;
      chk("bounce_stable", 32'(stable_o[1]), 32'h0);
    end
    raw_i[1] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(1);
      if (rise_o[1]) rise_cnt++;
    end
    chk("bounce_before", 32'(stable_o[1]), 32'h0);
    step(1);
    if (rise_o[1]) rise_cnt++;
    chk("bounce_stable_hi", 32'(stable_o), 32'h3);
    chk("bounce_rise", 32'(rise_o), 32'h2);
    step(2);
    if (rise_o[1]) rise_cnt++;
    chk("bounce_rise_count", 32'(rise_cnt), 32'd1);

    // 4. multi-bit transitions
    raw_i = 4'h0;
    step(10);
    chk("multi_idle", 32'(stable_o), 32'h0);
    raw_i = 4'hA;
    step(5);
    chk("multi_rise_early", 32'(rise_o), 32'h0);
    step(1);
    chk("multi_rise", 32'(rise_o), 32'hA);
    chk("multi_rise_fall", 32'(fall_o), 32'h0);
    chk("multi_rise_stable", 32'(stable_o), 32'hA);
    step(1);
    chk("multi_rise_end", 32'(rise_o), 32'h0);
    raw_i = 4'h0;
    step(6);
    chk("multi_fall", 32'(fall_o), 32'hA);
    chk("multi_fall_rise", 32'(rise_o), 32'h0);
    chk("multi_fall_stable", 32'(stable_o), 32'h0);
    step(1);
    chk("multi_fall_end", 32'(fall_o), 32'h0);

    // 5. pending bits and irq
    clr_i = 4'hF;
    step(1);
    clr_i = 4'h0;
    chk("irq_cleared_pend", 32'(pend_o), 32'h0);
    chk("irq_cleared_irq", 32'(irq_o), 32'h0);
    raw_i = 4'h4;
    step(6);
    chk("irq_rise", 32'(rise_o), 32'h4);
    step(1);
    chk("irq_pend_set", 32'(pend_o), IrqEn ? 32'h4 : 32'h0);
    chk("irq_irq_set", 32'(irq_o), IrqEn ? 32'h1 : 32'h0);
    raw_i = 4'h0;
    step(6);
    chk("irq_fall", 32'(fall_o), 32'h4);
    clr_i = 4'h4;
    step(1);
    clr_i = 4'h0;
    chk("irq_set_wins", 32'(pend_o), IrqEn ? 32'h4 : 32'h0);
    clr_i = 4'h4;
    step(1);
    clr_i = 4'h0;
    chk("irq_clr_pend", 32'(pend_o), 32'h0);
    chk("irq_clr_irq", 32'(irq_o), 32'h0);

    // 6. reset in the middle of a count
    raw_i = 4'h8;
    step(4);
    chk("midrst_pre", 32'(stable_o), 32'h0);
    reset_n = 1'b0;
    #1;
    chk_quiet("midrst_in");
    step(1);
    reset_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(1);
      chk("midrst_wait", 32'(stable_o), 32'h0);
    end
    step(1);
    chk("midrst_stable", 32'(stable_o), 32'h8);
    chk("midrst_rise", 32'(rise_o), 32'h8);
    step(1);
    chk("midrst_rise_end", 32'(rise_o), 32'h0);
    chk("midrst_hold", 32'(stable_o), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
